// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared ALU opcode, alu_op class, funct and forward-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam logic [3:0] C_ALU_ADD  = 4'b0010;
  localparam logic [3:0] C_ALU_SUB  = 4'b0110;
  localparam logic [3:0] C_ALU_AND  = 4'b0000;
  localparam logic [3:0] C_ALU_OR   = 4'b0001;
  localparam logic [3:0] C_ALU_NOR  = 4'b1100;
  localparam logic [3:0] C_ALU_PASS = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_t;

  localparam logic [5:0] C_FUNCT_ADD = 6'b100000;
  localparam logic [5:0] C_FUNCT_SUB = 6'b100010;
  localparam logic [5:0] C_FUNCT_AND = 6'b100100;
  localparam logic [5:0] C_FUNCT_OR  = 6'b100101;
  localparam logic [5:0] C_FUNCT_NOR = 6'b100111;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // The younger EX/MEM result always shadows MEM/WB.
  function automatic fwd_sel_t fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_alu_control.sv
// ============================================================================
// Module      : alu_control
// Description : Combinational alu_op class / funct to 4-bit ALU opcode decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_opcode
);

  always_comb begin
    alu_opcode = C_ALU_PASS;
    case (alu_op)
      ALUOP_ADD: alu_opcode = C_ALU_ADD;
      ALUOP_SUB: alu_opcode = C_ALU_SUB;
      ALUOP_OR:  alu_opcode = C_ALU_OR;
      default: begin
        case (funct)
          C_FUNCT_ADD: alu_opcode = C_ALU_ADD;
          C_FUNCT_SUB: alu_opcode = C_ALU_SUB;
          C_FUNCT_AND: alu_opcode = C_ALU_AND;
          C_FUNCT_OR:  alu_opcode = C_ALU_OR;
          C_FUNCT_NOR: alu_opcode = C_ALU_NOR;
          default:     alu_opcode = C_ALU_PASS;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with ALU-control decode and operand
//               forwarding (forwarding muxes built when ID_EX_FORWARDING_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] rs_data,
  input  logic [WORD_WIDTH-1:0] rt_data,
  input  logic [WORD_WIDTH-1:0] imm,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  input  logic [1:0]            alu_op,
  input  logic [5:0]            funct,
  input  logic                  alu_src,
  input  logic                  reg_write,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WORD_WIDTH-1:0] exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WORD_WIDTH-1:0] memwb_result,
  output logic [WORD_WIDTH-1:0] a_operand,
  output logic [WORD_WIDTH-1:0] b_operand,
  output logic [3:0]            alu_opcode,
  output logic [WORD_WIDTH-1:0] store_data,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  ex_reg_write,
  output logic                  ex_valid
);

  logic [3:0]            w_opcode;
  logic                  r_valid;
  logic                  r_reg_write;
  logic                  r_alu_src;
  logic [3:0]            r_opcode;
  logic [WORD_WIDTH-1:0] r_rs_data;
  logic [WORD_WIDTH-1:0] r_rt_data;
  logic [WORD_WIDTH-1:0] r_imm;
  logic [REG_ADDR_W-1:0] r_rs_addr;
  logic [REG_ADDR_W-1:0] r_rt_addr;
  logic [REG_ADDR_W-1:0] r_dst;
  logic [WORD_WIDTH-1:0] w_rs_fwd;
  logic [WORD_WIDTH-1:0] w_rt_fwd;

  alu_control u_alu_control (
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_opcode (w_opcode)
  );

  // Flush or an invalid ID slot loads the bubble; stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_opcode    <= C_ALU_ADD;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_dst       <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_opcode    <= C_ALU_ADD;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_dst       <= '0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_reg_write <= reg_write;
      r_alu_src   <= alu_src;
      r_opcode    <= w_opcode;
      r_rs_data   <= rs_data;
      r_rt_data   <= rt_data;
      r_imm       <= imm;
      r_rs_addr   <= rs_addr;
      r_rt_addr   <= rt_addr;
      r_dst       <= dst_addr;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  fwd_sel_t w_rs_sel;
  fwd_sel_t w_rt_sel;

  assign w_rs_sel = fwd_select(exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs_addr),
                               memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs_addr));
  assign w_rt_sel = fwd_select(exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt_addr),
                               memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt_addr));

  always_comb begin
    w_rs_fwd = r_rs_data;
    w_rt_fwd = r_rt_data;
    case (w_rs_sel)
      FWD_EXMEM: w_rs_fwd = exmem_result;
      FWD_MEMWB: w_rs_fwd = memwb_result;
      default:   w_rs_fwd = r_rs_data;
    endcase
    case (w_rt_sel)
      FWD_EXMEM: w_rt_fwd = exmem_result;
      FWD_MEMWB: w_rt_fwd = memwb_result;
      default:   w_rt_fwd = r_rt_data;
    endcase
  end
`else
  // Hazard unit stalls on every RAW here, so forwarding sources are dead.
  logic w_unused_fwd;

  assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result,
                          r_rs_addr, r_rt_addr};
  assign w_rs_fwd = r_rs_data;
  assign w_rt_fwd = r_rt_data;
`endif

  assign a_operand    = w_rs_fwd;
  assign b_operand    = r_alu_src ? r_imm : w_rt_fwd;
  assign store_data   = w_rt_fwd;
  assign alu_opcode   = r_opcode;
  assign ex_dst       = r_dst;
  assign ex_reg_write = r_reg_write;
  assign ex_valid     = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, dst_addr;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src, reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] a_operand, b_operand, store_data;
  logic [3:0]  alu_opcode;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_valid;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.WORD_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .imm             (imm),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .dst_addr        (dst_addr),
    .alu_op          (alu_op),
    .funct           (funct),
    .alu_src         (alu_src),
    .reg_write       (reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .a_operand       (a_operand),
    .b_operand       (b_operand),
    .alu_opcode      (alu_opcode),
    .store_data      (store_data),
    .ex_dst          (ex_dst),
    .ex_reg_write    (ex_reg_write),
    .ex_valid        (ex_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    rs_data = 32'hDEAD; rt_data = 32'hBEEF; imm = 32'h1234;
    rs_addr = 5'd1; rt_addr = 5'd2; dst_addr = 5'd3;
    alu_op = 2'b10; funct = 6'b100010; alu_src = 1'b0; reg_write = 1'b1;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;

    // Reset held across edges with a valid instruction presented
    tick(); tick();
    check("rst_valid",  {31'd0, ex_valid}, 32'd0);
    check("rst_rw",     {31'd0, ex_reg_write}, 32'd0);
    check("rst_opcode", {28'd0, alu_opcode}, 32'h2);
    check("rst_dst",    {27'd0, ex_dst}, 32'd0);
    check("rst_a",      a_operand, 32'd0);
    check("rst_b",      b_operand, 32'd0);
    check("rst_store",  store_data, 32'd0);

    // First instruction: SUB 5 - 3
    rst_n = 1'b1;
    rs_data = 32'd5; rt_data = 32'd3;
    tick();
    check("cap_a",      a_operand, 32'd5);
    check("cap_b",      b_operand, 32'd3);
    check("cap_opcode", {28'd0, alu_opcode}, 32'h6);
    check("cap_valid",  {31'd0, ex_valid}, 32'd1);
    check("cap_rw",     {31'd0, ex_reg_write}, 32'd1);
    check("cap_dst",    {27'd0, ex_dst}, 32'd3);
    check("cap_store",  store_data, 32'd3);

    // Immediate B operand
    alu_src = 1'b1; imm = 32'hFFFF_FFFC; alu_op = 2'b00;
    tick();
    check("imm_b",      b_operand, 32'hFFFF_FFFC);
    check("imm_opcode", {28'd0, alu_opcode}, 32'h2);
    check("imm_store",  store_data, 32'd3);

    // Forwarding priority on the A path
    alu_src = 1'b0; rs_addr = 5'd4; rs_data = 32'h99; rt_addr = 5'd5; rt_data = 32'h55;
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h22;
    #1;
    check("fwd_exmem_a", a_operand, FWD ? 32'h11 : 32'h99);
    check("fwd_rt_none", b_operand, 32'h55);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb_a", a_operand, FWD ? 32'h22 : 32'h99);

    // Register 0 is never forwarded; rt path forwarding feeds b and store
    rs_addr = 5'd0; rs_data = 32'h77;
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check("fwd_r0_a", a_operand, 32'h77);
    exmem_rd = 5'd5;
    #1;
    check("fwd_rt_b",     b_operand, FWD ? 32'h11 : 32'h55);
    check("fwd_rt_store", store_data, FWD ? 32'h11 : 32'h55);
    check("fwd_r0_a2",    a_operand, 32'h77);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; exmem_rd = 5'd0;

    // Entry A, then stall three cycles while inputs change
    rs_addr = 5'd8; rt_addr = 5'd9; rs_data = 32'hA1; rt_data = 32'hA2;
    alu_op = 2'b01; dst_addr = 5'd7;
    tick();
    check("stallA_a", a_operand, 32'hA1);
    stall = 1'b1;
    rs_data = 32'hB1; rt_data = 32'hB2; alu_op = 2'b11; dst_addr = 5'd12; reg_write = 1'b0;
    tick(); tick(); tick();
    check("stall_a",      a_operand, 32'hA1);
    check("stall_b",      b_operand, 32'hA2);
    check("stall_opcode", {28'd0, alu_opcode}, 32'h6);
    check("stall_dst",    {27'd0, ex_dst}, 32'd7);
    check("stall_rw",     {31'd0, ex_reg_write}, 32'd1);
    stall = 1'b0;
    tick();
    check("unstall_a",      a_operand, 32'hB1);
    check("unstall_opcode", {28'd0, alu_opcode}, 32'h1);
    check("unstall_dst",    {27'd0, ex_dst}, 32'd12);

    // Flush wins over stall
    reg_write = 1'b1; flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_valid",  {31'd0, ex_valid}, 32'd0);
    check("flush_rw",     {31'd0, ex_reg_write}, 32'd0);
    check("flush_opcode", {28'd0, alu_opcode}, 32'h2);
    check("flush_a",      a_operand, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Invalid ID slot inserts a bubble
    in_valid = 1'b0;
    tick();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_dst",   {27'd0, ex_dst}, 32'd0);
    in_valid = 1'b1;

    // R-type funct decode
    alu_op = 2'b10;
    funct = 6'b101010; tick(); check("funct_pass", {28'd0, alu_opcode}, 32'hF);
    funct = 6'b100111; tick(); check("funct_nor",  {28'd0, alu_opcode}, 32'hC);
    funct = 6'b100100; tick(); check("funct_and",  {28'd0, alu_opcode}, 32'h0);
    funct = 6'b100101; tick(); check("funct_or",   {28'd0, alu_opcode}, 32'h1);
    funct = 6'b100000; tick(); check("funct_add",  {28'd0, alu_opcode}, 32'h2);
    check("funct_valid", {31'd0, ex_valid}, 32'd1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_a",     a_operand, 32'd0);
    check("arst_opcode", {28'd0, alu_opcode}, 32'h2);
    rst_n = 1'b1;
    tick();
    check("post_arst_valid", {31'd0, ex_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
